// File: rtl/execute_md_if.sv
// Connection bundle between the ID/EX side and the execute stage: issue fields,
// forwarding sources, flush and the EX/MEM register contents.
interface execute_md_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [4:0]      in_rd;
    logic [4:0]      in_op;
    logic            in_alu_src;
    logic            in_reg_write;
    logic            in_mem_read;
    logic            in_mem_write;
    logic            in_mem_to_reg;

    logic [4:0]      exm_rd;
    logic            exm_reg_write;
    logic [XLEN-1:0] exm_result;
    logic [4:0]      wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_data;

    logic            flush;

    logic            out_valid;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_store_data;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_mem_to_reg;
    logic            take_branch;
    logic [XLEN-1:0] branch_target;

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1, in_rs2, in_rd, in_op, in_alu_src,
               in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg,
               exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_data,
               flush,
        input  in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
               take_branch, branch_target
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1, in_rs2, in_rd, in_op, in_alu_src,
               in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg,
               exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_data,
               flush,
        output in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
               take_branch, branch_target
    );
endinterface

// File: rtl/execute_md_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and branch resolution, and a
// radix-2 iterative multiply/divide unit that holds the stage busy for XLEN cycles.
module execute_md_stage #(
    parameter int XLEN  = 32,
    parameter int MD_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    execute_md_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    localparam bit MD_ITER = (MD_EN != 0);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_BEQ    = 5'd10;
    localparam logic [4:0] OP_BNE    = 5'd11;
    localparam logic [4:0] OP_BLT    = 5'd12;
    localparam logic [4:0] OP_BGE    = 5'd13;
    localparam logic [4:0] OP_BLTU   = 5'd14;
    localparam logic [4:0] OP_BGEU   = 5'd15;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;
    localparam logic [4:0] OP_JAL    = 5'd24;
    localparam logic [4:0] OP_JALR   = 5'd25;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg;
    logic [SW-1:0]   count_reg;

    logic            out_valid_reg;
    logic [XLEN-1:0] out_result_reg;
    logic [XLEN-1:0] out_store_reg;
    logic [4:0]      out_rd_reg;
    logic            out_reg_write_reg;
    logic            out_mem_read_reg;
    logic            out_mem_write_reg;
    logic            out_mem_to_reg_reg;
    logic            take_branch_reg;
    logic [XLEN-1:0] branch_target_reg;

    logic [4:0]      md_op_reg;
    logic            md_neg_reg;
    logic            md_div0_reg;
    logic [XLEN-1:0] md_dividend_reg;
    logic [XLEN-1:0] acc_reg;
    logic [XLEN-1:0] work_reg;
    logic [XLEN-1:0] mcand_reg;
    logic [XLEN-1:0] md_store_reg;
    logic [4:0]      md_rd_reg;
    logic            md_reg_write_reg;
    logic            md_mem_read_reg;
    logic            md_mem_write_reg;
    logic            md_mem_to_reg_reg;

    logic            in_ready;
    logic            accept;
    logic [4:0]      op;

    assign in_ready = reset & (state_reg == IDLE);
    assign accept   = bus.in_valid & in_ready;
    assign op       = (bus.in_op > OP_JALR) ? OP_ADD : bus.in_op;

    // Operand forwarding: EX/MEM beats MEM/WB, and x0 is never forwarded.
    logic [4:0]      src_idx [2];
    logic [XLEN-1:0] src_rf  [2];
    logic [XLEN-1:0] src_fwd [2];

    assign src_idx[0] = bus.in_rs1;
    assign src_idx[1] = bus.in_rs2;
    assign src_rf[0]  = bus.in_rs1_data;
    assign src_rf[1]  = bus.in_rs2_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign src_fwd[gi] =
                (bus.exm_reg_write && bus.exm_rd == src_idx[gi] && src_idx[gi] != 5'd0) ? bus.exm_result :
                (bus.wb_reg_write  && bus.wb_rd  == src_idx[gi] && src_idx[gi] != 5'd0) ? bus.wb_data :
                src_rf[gi];
        end
    endgenerate

    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] opnd_b;
    logic [SW-1:0]   shamt;

    assign rs1    = src_fwd[0];
    assign rs2    = src_fwd[1];
    assign opnd_b = (bus.in_alu_src && op <= OP_AND) ? bus.in_imm : rs2;
    assign shamt  = opnd_b[SW-1:0];

    // Branches leave out_result at zero; mul/div ops also do when MD_EN=0.
    logic [XLEN-1:0] alu_res;
    logic            br_cond;
    logic            is_ctrl;
    logic [XLEN-1:0] br_target;
    logic            is_md;

    always_comb begin
        alu_res = '0;
        br_cond = 1'b0;
        is_ctrl = 1'b0;
        case (op)
            OP_ADD:  alu_res = rs1 + opnd_b;
            OP_SUB:  alu_res = rs1 - opnd_b;
            OP_SLL:  alu_res = rs1 << shamt;
            OP_SLT:  alu_res = XLEN'($signed(rs1) < $signed(opnd_b));
            OP_SLTU: alu_res = XLEN'(rs1 < opnd_b);
            OP_XOR:  alu_res = rs1 ^ opnd_b;
            OP_SRL:  alu_res = rs1 >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(rs1) >>> shamt);
            OP_OR:   alu_res = rs1 | opnd_b;
            OP_AND:  alu_res = rs1 & opnd_b;
            OP_BEQ:  begin is_ctrl = 1'b1; br_cond = (rs1 == rs2); end
            OP_BNE:  begin is_ctrl = 1'b1; br_cond = (rs1 != rs2); end
            OP_BLT:  begin is_ctrl = 1'b1; br_cond = ($signed(rs1) < $signed(rs2)); end
            OP_BGE:  begin is_ctrl = 1'b1; br_cond = ($signed(rs1) >= $signed(rs2)); end
            OP_BLTU: begin is_ctrl = 1'b1; br_cond = (rs1 < rs2); end
            OP_BGEU: begin is_ctrl = 1'b1; br_cond = (rs1 >= rs2); end
            OP_JAL, OP_JALR: begin
                is_ctrl = 1'b1;
                br_cond = 1'b1;
                alu_res = bus.in_pc + XLEN'(4);
            end
            default: alu_res = '0;
        endcase
    end

    assign br_target = (op == OP_JALR) ? ((rs1 + bus.in_imm) & ~XLEN'(1)) : (bus.in_pc + bus.in_imm);
    assign is_md     = (op[4:3] == 2'b10);

    // Mul/div setup: iterate on magnitudes, remember the sign fix-up for the end.
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            res_neg;

    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg    = a_signed & rs1[XLEN-1];
    assign b_neg    = b_signed & rs2[XLEN-1];
    assign a_mag    = a_neg ? ('0 - rs1) : rs1;
    assign b_mag    = b_neg ? ('0 - rs2) : rs2;
    assign res_neg  = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);

    // One radix-2 step: shift-add for multiply, restoring subtract for divide (op bit 2).
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;
    logic [XLEN-1:0]   acc_next;
    logic [XLEN-1:0]   work_next;

    always_comb begin
        mul_sum  = {1'b0, acc_reg} + (work_reg[0] ? {1'b0, mcand_reg} : '0);
        rem_sh   = {acc_reg, work_reg[XLEN-1]};
        rem_diff = rem_sh - {1'b0, mcand_reg};
        if (md_op_reg[2]) begin
            if (!rem_diff[XLEN]) begin
                acc_next  = rem_diff[XLEN-1:0];
                work_next = {work_reg[XLEN-2:0], 1'b1};
            end else begin
                acc_next  = rem_sh[XLEN-1:0];
                work_next = {work_reg[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next  = mul_sum[XLEN:1];
            work_next = {mul_sum[0], work_reg[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   md_result;

    always_comb begin
        prod_mag = {acc_next, work_next};
        prod     = md_neg_reg ? ('0 - prod_mag) : prod_mag;
        quo      = md_neg_reg ? ('0 - work_next) : work_next;
        rem      = md_neg_reg ? ('0 - acc_next) : acc_next;
        case (md_op_reg)
            OP_MUL:                        md_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  md_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               md_result = md_div0_reg ? '1 : quo;
            OP_REM, OP_REMU:               md_result = md_div0_reg ? md_dividend_reg : rem;
            default:                       md_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg          <= IDLE;
            count_reg          <= '0;
            out_valid_reg      <= 1'b0;
            out_result_reg     <= '0;
            out_store_reg      <= '0;
            out_rd_reg         <= '0;
            out_reg_write_reg  <= 1'b0;
            out_mem_read_reg   <= 1'b0;
            out_mem_write_reg  <= 1'b0;
            out_mem_to_reg_reg <= 1'b0;
            take_branch_reg    <= 1'b0;
            branch_target_reg  <= '0;
            md_op_reg          <= '0;
            md_neg_reg         <= 1'b0;
            md_div0_reg        <= 1'b0;
            md_dividend_reg    <= '0;
            acc_reg            <= '0;
            work_reg           <= '0;
            mcand_reg          <= '0;
            md_store_reg       <= '0;
            md_rd_reg          <= '0;
            md_reg_write_reg   <= 1'b0;
            md_mem_read_reg    <= 1'b0;
            md_mem_write_reg   <= 1'b0;
            md_mem_to_reg_reg  <= 1'b0;
        end else begin
            // Default to a bubble; the cases below overwrite when a result lands.
            out_valid_reg     <= 1'b0;
            out_reg_write_reg <= 1'b0;
            out_mem_read_reg  <= 1'b0;
            out_mem_write_reg <= 1'b0;
            take_branch_reg   <= 1'b0;

            if (bus.flush) begin
                state_reg <= IDLE;
                count_reg <= '0;
            end else if (state_reg == IDLE) begin
                if (accept && is_md && MD_ITER) begin
                    state_reg         <= BUSY;
                    count_reg         <= SW'(XLEN - 1);
                    md_op_reg         <= op;
                    md_neg_reg        <= res_neg;
                    md_div0_reg       <= (rs2 == '0);
                    md_dividend_reg   <= rs1;
                    acc_reg           <= '0;
                    work_reg          <= op[2] ? a_mag : b_mag;
                    mcand_reg         <= op[2] ? b_mag : a_mag;
                    md_store_reg      <= rs2;
                    md_rd_reg         <= bus.in_rd;
                    md_reg_write_reg  <= bus.in_reg_write;
                    md_mem_read_reg   <= bus.in_mem_read;
                    md_mem_write_reg  <= bus.in_mem_write;
                    md_mem_to_reg_reg <= bus.in_mem_to_reg;
                end else if (accept) begin
                    out_valid_reg      <= 1'b1;
                    out_result_reg     <= alu_res;
                    out_store_reg      <= rs2;
                    out_rd_reg         <= bus.in_rd;
                    out_reg_write_reg  <= bus.in_reg_write;
                    out_mem_read_reg   <= bus.in_mem_read;
                    out_mem_write_reg  <= bus.in_mem_write;
                    out_mem_to_reg_reg <= bus.in_mem_to_reg;
                    take_branch_reg    <= is_ctrl & br_cond;
                    branch_target_reg  <= br_target;
                end
            end else begin
                acc_reg  <= acc_next;
                work_reg <= work_next;
                if (count_reg == '0) begin
                    state_reg          <= IDLE;
                    out_valid_reg      <= 1'b1;
                    out_result_reg     <= md_result;
                    out_store_reg      <= md_store_reg;
                    out_rd_reg         <= md_rd_reg;
                    out_reg_write_reg  <= md_reg_write_reg;
                    out_mem_read_reg   <= md_mem_read_reg;
                    out_mem_write_reg  <= md_mem_write_reg;
                    out_mem_to_reg_reg <= md_mem_to_reg_reg;
                    branch_target_reg  <= '0;
                end else begin
                    count_reg <= count_reg - 1'b1;
                end
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_reg;
    assign bus.out_result     = out_result_reg;
    assign bus.out_store_data = out_store_reg;
    assign bus.out_rd         = out_rd_reg;
    assign bus.out_reg_write  = out_reg_write_reg;
    assign bus.out_mem_read   = out_mem_read_reg;
    assign bus.out_mem_write  = out_mem_write_reg;
    assign bus.out_mem_to_reg = out_mem_to_reg_reg;
    assign bus.take_branch    = take_branch_reg;
    assign bus.branch_target  = branch_target_reg;
endmodule

// File: tb/tb_execute_md_stage.sv
// Directed bench for execute_md_stage: stimulus pushes hand-computed expectations into a
// scoreboard queue, a negedge monitor pops and compares each valid EX/MEM output.
module tb_execute_md_stage;
    localparam int XLEN = 32;

    typedef struct {
        string       name;
        logic [31:0] result;
        bit          chk_res;
        logic [31:0] store;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic        tb;
        logic [31:0] tgt;
        bit          chk_tgt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   vid = 0;
    int   ready_low;
    exp_t sb[$];
    exp_t mon_e;
    bit   mon_ok;

    execute_md_if #(.XLEN(XLEN)) bus ();

    execute_md_stage #(.XLEN(XLEN), .MD_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got result=%h rd=%0d, required no output", bus.out_result, bus.out_rd);
            end else begin
                mon_e  = sb.pop_front();
                mon_ok = (!mon_e.chk_res || bus.out_result === mon_e.result) &&
                         (bus.out_store_data === mon_e.store) && (bus.out_rd === mon_e.rd) &&
                         ({bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg} === mon_e.ctl) &&
                         (bus.take_branch === mon_e.tb) &&
                         (!mon_e.chk_tgt || bus.branch_target === mon_e.tgt);
                if (!mon_ok) begin
                    n_bad++;
                    $display("FAIL %s: got result=%h store=%h rd=%0d ctl=%b take=%b target=%h, required result=%h store=%h rd=%0d ctl=%b take=%b target=%h",
                             mon_e.name, bus.out_result, bus.out_store_data, bus.out_rd,
                             {bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg},
                             bus.take_branch, bus.branch_target, mon_e.result, mon_e.store, mon_e.rd,
                             mon_e.ctl, mon_e.tb, mon_e.tgt);
                end else begin
                    $display("ok   %-14s result=%h take=%b target=%h", mon_e.name, bus.out_result,
                             bus.take_branch, bus.branch_target);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok   %-14s value=%h", name, act);
        end
    endtask

    task automatic wait_ready();
        int waited = 0;
        while (!bus.in_ready && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: got in_ready=0 after 64 cycles, required 1");
        end
    endtask

    task automatic drive(input string name, input logic [4:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic asrc,
                         input logic [31:0] e_res, input bit c_res, input logic [31:0] e_store,
                         input logic e_tb, input logic [31:0] e_tgt, input bit c_tgt, input bit e_out);
        exp_t e;
        logic [31:0] v;
        wait_ready();
        vid++;
        v = vid;
        bus.in_valid      = 1'b1;
        bus.in_op         = op;
        bus.in_rs1        = r1;
        bus.in_rs2        = r2;
        bus.in_rs1_data   = d1;
        bus.in_rs2_data   = d2;
        bus.in_imm        = imm;
        bus.in_pc         = pc;
        bus.in_alu_src    = asrc;
        bus.in_rd         = 5'((vid % 31) + 1);
        bus.in_reg_write  = ~v[0];
        bus.in_mem_read   = v[1];
        bus.in_mem_write  = v[2];
        bus.in_mem_to_reg = v[3];
        e.name    = name;
        e.result  = e_res;
        e.chk_res = c_res;
        e.store   = e_store;
        e.rd      = 5'((vid % 31) + 1);
        e.ctl     = {~v[0], v[1], v[2], v[3]};
        e.tb      = e_tb;
        e.tgt     = e_tgt;
        e.chk_tgt = c_tgt;
        if (e_out) sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic alu(input string name, input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] exp_res);
        drive(name, op, 5'd1, 5'd2, d1, d2, 32'h0, 32'h0, 1'b0, exp_res, 1, d2, 1'b0, 32'h0, 0, 1);
    endtask

    task automatic br(input string name, input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] pc, input logic [31:0] imm, input logic taken, input logic [31:0] tgt);
        drive(name, op, 5'd1, 5'd2, d1, d2, imm, pc, 1'b1, 32'h0, 0, d2, taken, tgt, taken, 1);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_pc = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0;
        bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0; bus.in_op = 0; bus.in_alu_src = 0;
        bus.in_reg_write = 0; bus.in_mem_read = 0; bus.in_mem_write = 0; bus.in_mem_to_reg = 0;
        bus.exm_rd = 0; bus.exm_reg_write = 0; bus.exm_result = 0;
        bus.wb_rd = 0; bus.wb_reg_write = 0; bus.wb_data = 0; bus.flush = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.in_ready), 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_result", bus.out_result, 32'h0);
        check("rst_take", 32'(bus.take_branch), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(bus.in_ready), 32'h1);

        // Forwarding: EX/MEM wins over MEM/WB, MEM/WB used alone, x0 never forwarded.
        bus.exm_rd = 5'd5; bus.exm_reg_write = 1; bus.exm_result = 32'd10;
        bus.wb_rd = 5'd5; bus.wb_reg_write = 1; bus.wb_data = 32'd20;
        drive("fwd_exm", 5'd0, 5'd5, 5'd6, 32'h111, 32'd3, 0, 0, 0, 32'd13, 1, 32'd3, 0, 0, 0, 1);
        bus.exm_rd = 5'd9; bus.exm_result = 32'd55; bus.wb_rd = 5'd8; bus.wb_data = 32'd100;
        drive("fwd_wb", 5'd0, 5'd7, 5'd8, 32'd1, 32'h999, 0, 0, 0, 32'd101, 1, 32'd100, 0, 0, 0, 1);
        bus.exm_rd = 5'd0; bus.exm_result = 32'hDEAD; bus.wb_reg_write = 0;
        drive("fwd_x0", 5'd0, 5'd0, 5'd9, 32'd0, 32'h55, 0, 0, 0, 32'h55, 1, 32'h55, 0, 0, 0, 1);
        bus.exm_reg_write = 0;

        alu("sub",  5'd1, 32'd3, 32'd5, 32'hFFFFFFFE);
        alu("sll",  5'd2, 32'd1, 32'd35, 32'd8);
        alu("slt",  5'd3, 32'hFFFFFFFF, 32'd1, 32'd1);
        alu("sltu", 5'd4, 32'hFFFFFFFF, 32'd1, 32'd0);
        alu("xor",  5'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
        alu("srl",  5'd6, 32'h80000000, 32'd4, 32'h08000000);
        alu("sra",  5'd7, 32'h80000000, 32'd4, 32'hF8000000);
        alu("or",   5'd8, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0);
        alu("and",  5'd9, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        alu("add_wrap", 5'd0, 32'hFFFFFFFF, 32'd2, 32'd1);
        alu("op30_add", 5'd30, 32'd2, 32'd3, 32'd5);
        drive("addi", 5'd0, 5'd1, 5'd2, 32'd100, 32'd7, 32'hFFFFFFFF, 0, 1, 32'd99, 1, 32'd7, 0, 0, 0, 1);

        br("blt",  5'd12, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 1, 32'h120);
        br("beq_nt", 5'd10, 32'd1, 32'd2, 32'h100, 32'h20, 0, 32'h0);
        br("bne",  5'd11, 32'd1, 32'd2, 32'h180, 32'hFFFFFFF0, 1, 32'h170);
        br("bge_nt", 5'd13, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 0, 32'h0);
        br("bltu_nt", 5'd14, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 0, 32'h0);
        br("bgeu", 5'd15, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h40, 1, 32'h140);
        drive("jal",  5'd24, 5'd1, 5'd2, 32'd0, 32'd0, 32'h40, 32'h200, 0, 32'h204, 1, 32'd0, 1, 32'h240, 1, 1);
        drive("jalr", 5'd25, 5'd1, 5'd2, 32'h301, 32'd0, 32'h10, 32'h400, 0, 32'h404, 1, 32'd0, 1, 32'h310, 1, 1);

        // DIV latency: in_ready low for XLEN cycles, result in cycle T+XLEN+1.
        drive("div_m7_2", 5'd20, 5'd1, 5'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 32'hFFFFFFFD, 1, 32'd2, 0, 0, 0, 1);
        ready_low = 0;
        for (int j = 0; j < XLEN; j++) begin
            if (!bus.in_ready) ready_low++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 32'(ready_low), 32'd32);
        check("div_valid_t33", {30'd0, bus.out_valid, bus.in_ready}, 32'h3);

        drive("rem_m7_2",  5'd22, 5'd1, 5'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 32'hFFFFFFFF, 1, 32'd2, 0, 0, 0, 1);
        drive("divu_5_0",  5'd21, 5'd1, 5'd2, 32'd5, 32'd0, 0, 0, 0, 32'hFFFFFFFF, 1, 32'd0, 0, 0, 0, 1);
        drive("remu_5_0",  5'd23, 5'd1, 5'd2, 32'd5, 32'd0, 0, 0, 0, 32'd5, 1, 32'd0, 0, 0, 0, 1);
        drive("div_ovf",   5'd20, 5'd1, 5'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 32'h80000000, 1, 32'hFFFFFFFF, 0, 0, 0, 1);
        drive("rem_ovf",   5'd22, 5'd1, 5'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 32'd0, 1, 32'hFFFFFFFF, 0, 0, 0, 1);
        drive("div_m5_0",  5'd20, 5'd1, 5'd2, 32'hFFFFFFFB, 32'd0, 0, 0, 0, 32'hFFFFFFFF, 1, 32'd0, 0, 0, 0, 1);
        drive("rem_m5_0",  5'd22, 5'd1, 5'd2, 32'hFFFFFFFB, 32'd0, 0, 0, 0, 32'hFFFFFFFB, 1, 32'd0, 0, 0, 0, 1);
        drive("divu_100_7", 5'd21, 5'd1, 5'd2, 32'd100, 32'd7, 0, 0, 0, 32'd14, 1, 32'd7, 0, 0, 0, 1);
        drive("remu_100_7", 5'd23, 5'd1, 5'd2, 32'd100, 32'd7, 0, 0, 0, 32'd2, 1, 32'd7, 0, 0, 0, 1);
        drive("mulh_min",  5'd17, 5'd1, 5'd2, 32'h80000000, 32'h80000000, 0, 0, 0, 32'h40000000, 1, 32'h80000000, 0, 0, 0, 1);
        drive("mulhsu_m1", 5'd18, 5'd1, 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0, 0, 1);
        drive("mulhu_max", 5'd19, 5'd1, 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFE, 1, 32'hFFFFFFFF, 0, 0, 0, 1);
        drive("mul_7_m3",  5'd16, 5'd1, 5'd2, 32'd7, 32'hFFFFFFFD, 0, 0, 0, 32'hFFFFFFEB, 1, 32'hFFFFFFFD, 0, 0, 0, 1);
        drive("mulh_m2_3", 5'd17, 5'd1, 5'd2, 32'hFFFFFFFE, 32'd3, 0, 0, 0, 32'hFFFFFFFF, 1, 32'd3, 0, 0, 0, 1);
        bus.exm_rd = 5'd3; bus.exm_reg_write = 1; bus.exm_result = 32'd6;
        drive("mul_fwd", 5'd16, 5'd3, 5'd4, 32'd99, 32'd7, 0, 0, 0, 32'd42, 1, 32'd7, 0, 0, 0, 1);
        bus.exm_reg_write = 0;

        // Flush at BUSY cycle 10 aborts the divide without a result.
        drive("divu_flushed", 5'd21, 5'd1, 5'd2, 32'd100, 32'd7, 0, 0, 0, 32'd14, 1, 32'd7, 0, 0, 0, 0);
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_ready", 32'(bus.in_ready), 32'h1);
        check("flush_bubble", 32'(bus.out_valid), 32'h0);

        // Flush wins over an accept in the same cycle.
        bus.flush = 1'b1;
        drive("add_flushed", 5'd0, 5'd1, 5'd2, 32'd1, 32'd1, 0, 0, 0, 32'd2, 1, 32'd1, 0, 0, 0, 0);
        bus.flush = 1'b0;
        check("flush_accept", 32'(bus.out_valid), 32'h0);
        alu("after_flush", 5'd0, 32'd40, 32'd2, 32'd42);

        // Reset mid-BUSY: no result may appear afterwards.
        drive("mul_reset", 5'd16, 5'd1, 5'd2, 32'd3, 32'd3, 0, 0, 0, 32'd9, 1, 32'd3, 0, 0, 0, 0);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", 32'(bus.in_ready), 32'h0);
        check("midrst_valid", 32'(bus.out_valid), 32'h0);
        reset = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        alu("after_reset", 5'd1, 32'd50, 32'd8, 32'd42);

        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
